// File: rtl/apb_bridge_pkg.sv
// apb_bridge_pkg: shared ctrl-word layout and arbiter state encoding for the APB bridge.
package apb_bridge_pkg;
  localparam int CTRL_W         = 41;
  localparam int CTRL_WRITE_BIT = 40;
  localparam int CTRL_ID_MSB    = 39;
  localparam int CTRL_ID_LSB    = 32;
  localparam int CTRL_ADDR_MSB  = 31;
  localparam int CTRL_ADDR_LSB  = 0;
  typedef enum logic {ARB, PUSH} arb_state_e;
endpackage

// File: rtl/apb_owner_fifo.sv
// apb_owner_fifo: in-order record of which requester owns each outstanding read.
module apb_owner_fifo #(
  parameter int W     = 1,
  parameter int DEPTH = 4
) (
  input  logic         pclk,
  input  logic         resetn,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] cnt_q;
  logic do_push, do_pop;
  assign full_o  = cnt_q == (AW+1)'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign dout_o  = mem_q[rd_q];
  // a push into a full FIFO is only legal when the head leaves in the same cycle
  assign do_push = push_i & (!full_o | pop_i);
  assign do_pop  = pop_i & !empty_o;
  always_ff @(posedge pclk or negedge resetn)
    if (!resetn) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= do_push ? wr_q + 1'b1 : wr_q;
      rd_q  <= do_pop ? rd_q + 1'b1 : rd_q;
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  always_ff @(posedge pclk)
    if (do_push) mem_q[wr_q] <= din_i;
endmodule

// File: rtl/apb_cmd_arbiter.sv
// apb_cmd_arbiter: shares one APB master FSM between NUM_REQ requesters and routes read data back.
// Optional APB_ARB_STRICT_PRIO_EN selects fixed lowest-index priority instead of round-robin.
module apb_cmd_arbiter
  import apb_bridge_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 32,
  parameter int TAG_DEPTH  = 4
) (
  input  logic                          pclk,
  input  logic                          resetn,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_write,
  input  logic [NUM_REQ*32-1:0]         req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          ctrl_wen,
  output logic [CTRL_W-1:0]             ctrl_wdata,
  input  logic                          ctrl_full,
  output logic                          ahb_data_wen,
  output logic [DATA_WIDTH-1:0]         ahb_data_wdata,
  input  logic                          ahb_data_full,
  output logic                          apb_data_ren,
  input  logic [DATA_WIDTH-1:0]         apb_data_rdata,
  input  logic                          apb_data_empty,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  output logic                          busy
);
  localparam int IDW = $clog2(NUM_REQ);
  arb_state_e state_q, state_d;
  logic [IDW-1:0] rr_q, rr_d, win_q, win_d, win, of_dout;
  logic wr_q, wr_d, found, ren_q, pop, of_full, of_empty;
  logic [31:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d, rsp_rdata_q;
  logic [NUM_REQ-1:0] elig, rsp_valid_q;
  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_REQ; i++)
      elig[i] = req_valid[i] & !ctrl_full & (req_write[i] ? !ahb_data_full : !of_full);
    found = 1'b0;
    win   = '0;
    // scanning from rr_q also gives lowest-index priority when rr_q is held at 0
    for (int k = 0; k < NUM_REQ; k++)
      if (!found && elig[(int'(rr_q) + k) % NUM_REQ]) begin
        found = 1'b1;
        win   = IDW'((int'(rr_q) + k) % NUM_REQ);
      end
  end
  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    win_d     = win_q;
    wr_d      = wr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    req_ready = '0;
    if (state_q == ARB) begin
      if (found) begin
        req_ready[win] = 1'b1;
        state_d        = PUSH;
        win_d          = win;
        wr_d           = req_write[win];
        addr_d         = req_addr[32*int'(win) +: 32];
        wdata_d        = req_wdata[DATA_WIDTH*int'(win) +: DATA_WIDTH];
      end
    end else begin
      state_d = ARB;
`ifdef APB_ARB_STRICT_PRIO_EN
      rr_d    = '0;
`else
      rr_d    = (int'(win_q) == NUM_REQ - 1) ? '0 : win_q + 1'b1;
`endif
    end
  end
  always_ff @(posedge pclk or negedge resetn)
    if (!resetn) begin
      state_q     <= ARB;
      rr_q        <= '0;
      win_q       <= '0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      ren_q       <= 1'b0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      win_q       <= win_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      ren_q       <= pop;
      rsp_valid_q <= pop ? NUM_REQ'(1) << of_dout : '0;
      rsp_rdata_q <= pop ? apb_data_rdata : rsp_rdata_q;
    end
  always_comb begin
    ctrl_wdata                              = '0;
    ctrl_wdata[CTRL_WRITE_BIT]              = wr_q;
    ctrl_wdata[CTRL_ID_MSB:CTRL_ID_LSB]     = 8'(win_q);
    ctrl_wdata[CTRL_ADDR_MSB:CTRL_ADDR_LSB] = addr_q;
  end
  assign ctrl_wen       = state_q == PUSH;
  assign ahb_data_wen   = ctrl_wen & wr_q;
  assign ahb_data_wdata = wdata_q;
  // read data with no recorded owner is left in the FIFO rather than misrouted
  assign pop            = !apb_data_empty & !of_empty & !ren_q;
  assign apb_data_ren   = pop;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_rdata      = rsp_rdata_q;
  assign busy           = ctrl_wen | !of_empty;
  apb_owner_fifo #(.W(IDW), .DEPTH(TAG_DEPTH)) u_owner_fifo (
    .pclk    (pclk),
    .resetn  (resetn),
    .push_i  (ctrl_wen & !wr_q),
    .din_i   (win_q),
    .pop_i   (pop),
    .dout_o  (of_dout),
    .full_o  (of_full),
    .empty_o (of_empty)
  );
  a_orphan_rdata: assert property (@(posedge pclk) disable iff (!resetn) !(!apb_data_empty && of_empty));
endmodule

// File: tb/tb_apb_cmd_arbiter.sv
// tb_apb_cmd_arbiter: directed stimulus checked every cycle against a queue-based model of the arbiter.
module tb_apb_cmd_arbiter;
  localparam int N = 2, DW = 32, TD = 4;
  logic pclk = 1'b0, resetn = 1'b0;
  logic [N-1:0] req_valid = '0, req_write = '0, req_ready, rsp_valid;
  logic [N*32-1:0] req_addr = '0;
  logic [N*DW-1:0] req_wdata = '0;
  logic ctrl_wen, ahb_data_wen, apb_data_ren, busy;
  logic ctrl_full = 1'b0, ahb_data_full = 1'b0, apb_data_empty = 1'b1;
  logic [40:0] ctrl_wdata;
  logic [DW-1:0] ahb_data_wdata, rsp_rdata, apb_data_rdata = '0;
  always #5 pclk = ~pclk;
  apb_cmd_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .TAG_DEPTH(TD)) dut (
    .pclk(pclk), .resetn(resetn), .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
    .ctrl_wen(ctrl_wen), .ctrl_wdata(ctrl_wdata), .ctrl_full(ctrl_full),
    .ahb_data_wen(ahb_data_wen), .ahb_data_wdata(ahb_data_wdata), .ahb_data_full(ahb_data_full),
    .apb_data_ren(apb_data_ren), .apb_data_rdata(apb_data_rdata), .apb_data_empty(apb_data_empty),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy)
  );
  int checks = 0, failures = 0;
  bit sticky = 1'b0;
  bit m_push, m_wr, m_lastren, m_rspv;
  int m_w, m_rr, m_rspo;
  logic [31:0] m_addr, m_wdata, m_rspd;
  int owners[$];
  logic [DW-1:0] apbq[$];
  int glog[$];
  logic [N-1:0] rlog[$];
  logic [DW-1:0] dlog[$];
  logic [N-1:0] o_ready, o_rsp;
  logic o_cwen, o_awen, o_ren, o_busy;
  logic [40:0] o_cwd;
  logic [DW-1:0] o_awd;
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic model_reset();
    m_push = 0; m_wr = 0; m_lastren = 0; m_rspv = 0;
    m_w = 0; m_rr = 0; m_rspo = 0;
    owners.delete(); apbq.delete();
    apb_data_empty = 1'b1; apb_data_rdata = '0;
  endtask
  task automatic set_req(int i, bit v, bit wr, logic [31:0] a, logic [31:0] d);
    req_valid[i] = v; req_write[i] = wr;
    req_addr[32*i +: 32] = a; req_wdata[DW*i +: DW] = d;
  endtask
  task automatic inject(logic [DW-1:0] d);
    apbq.push_back(d);
    apb_data_empty = 1'b0;
    apb_data_rdata = apbq[0];
  endtask
  // one clock: compare at the falling edge, advance the model, then apply FIFO-side inputs after the rising edge
  task automatic cycle();
    int w = -1;
    logic [N-1:0] e_ready, e_rsp;
    logic e_ren;
    @(negedge pclk);
    if (!m_push)
      for (int k = 0; k < N; k++) begin
        int i = (m_rr + k) % N;
        if (w < 0 && req_valid[i] && !ctrl_full && (req_write[i] ? !ahb_data_full : owners.size() < TD)) w = i;
      end
    e_ready = (w >= 0) ? N'(1) << w : '0;
    e_ren   = apbq.size() > 0 && owners.size() > 0 && !m_lastren;
    e_rsp   = m_rspv ? N'(1) << m_rspo : '0;
    chk("req_ready", req_ready, e_ready);
    chk("ctrl_wen", ctrl_wen, m_push);
    if (m_push) chk("ctrl_wdata", ctrl_wdata, {m_wr, 8'(m_w), m_addr});
    chk("ahb_data_wen", ahb_data_wen, m_push && m_wr);
    if (m_push && m_wr) chk("ahb_data_wdata", ahb_data_wdata, m_wdata);
    chk("apb_data_ren", apb_data_ren, e_ren);
    chk("rsp_valid", rsp_valid, e_rsp);
    if (m_rspv) chk("rsp_rdata", rsp_rdata, m_rspd);
    chk("busy", busy, m_push || owners.size() > 0);
    o_ready = req_ready; o_cwen = ctrl_wen; o_cwd = ctrl_wdata; o_awen = ahb_data_wen;
    o_awd = ahb_data_wdata; o_ren = apb_data_ren; o_rsp = rsp_valid; o_busy = busy;
    if (req_ready != '0) glog.push_back(req_ready[1] ? 1 : 0);
    if (rsp_valid != '0) begin rlog.push_back(rsp_valid); dlog.push_back(rsp_rdata); end
    m_rspv = e_ren;
    if (e_ren) begin m_rspo = owners.pop_front(); m_rspd = apbq.pop_front(); end
    m_lastren = e_ren;
    if (m_push) begin
      if (!m_wr) owners.push_back(m_w);
`ifdef APB_ARB_STRICT_PRIO_EN
      m_rr = 0;
`else
      m_rr = (m_w + 1) % N;
`endif
      m_push = 0;
    end else if (w >= 0) begin
      m_push = 1; m_w = w; m_wr = req_write[w];
      m_addr = req_addr[32*w +: 32]; m_wdata = req_wdata[DW*w +: DW];
    end
    @(posedge pclk); #1;
    if (!sticky && w >= 0) req_valid[w] = 1'b0;
    apb_data_empty = apbq.size() == 0;
    apb_data_rdata = apbq.size() > 0 ? apbq[0] : '0;
  endtask
  initial begin
    logic [40:0] exp_cw;
    model_reset();
    repeat (3) @(posedge pclk);
    #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_ctrl_wen", ctrl_wen, 0);
    chk("rst_ctrl_wdata", ctrl_wdata, 0);
    chk("rst_ahb_wen", ahb_data_wen, 0);
    chk("rst_apb_ren", apb_data_ren, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    resetn = 1'b1;
    // two held reads: grants alternate until the owner FIFO is full
    sticky = 1'b1;
    set_req(0, 1, 0, 32'h2000, 0);
    set_req(1, 1, 0, 32'h3000, 0);
    glog.delete();
    repeat (10) cycle();
    req_valid = '0;
    sticky = 1'b0;
    chk("t2_ngrants", glog.size(), 4);
    for (int k = 0; k < 4; k++)
`ifdef APB_ARB_STRICT_PRIO_EN
      chk("t2_grant", k < glog.size() ? glog[k] : 99, 0);
`else
      chk("t2_grant", k < glog.size() ? glog[k] : 99, k % 2);
`endif
    cycle();
    chk("t3_busy_full", o_busy, 1);
    // owner FIFO full: the read stalls, the write still goes through
    set_req(0, 1, 1, 32'h4000, 32'h1111_2222);
    set_req(1, 1, 0, 32'h5000, 0);
    glog.delete();
    repeat (6) cycle();
    chk("t3_ngrants", glog.size(), 1);
    chk("t3_grant", glog.size() > 0 ? glog[0] : 99, 0);
    req_valid = '0;
    for (int k = 0; k < 4; k++) inject(32'hD000_0000 + k);
    rlog.delete(); dlog.delete();
    repeat (10) cycle();
    chk("t3_nrsp", rlog.size(), 4);
`ifdef APB_ARB_STRICT_PRIO_EN
    chk("t3_rsp1", rlog.size() > 1 ? rlog[1] : 0, 2'b01);
`else
    chk("t3_rsp1", rlog.size() > 1 ? rlog[1] : 0, 2'b10);
`endif
    chk("t3_rsp0", rlog.size() > 0 ? rlog[0] : 0, 2'b01);
    chk("t3_data0", dlog.size() > 0 ? dlog[0] : 0, 32'hD000_0000);
    chk("t3_data3", dlog.size() > 3 ? dlog[3] : 0, 32'hD000_0003);
    // single write: grant, then ctrl and data pushes one cycle later
    set_req(0, 1, 1, 32'h1000, 32'hA5A5_A5A5);
    cycle();
    chk("t1_ready", o_ready, 2'b01);
    cycle();
    exp_cw = {1'b1, 8'h00, 32'h0000_1000};
    chk("t1_ctrl_wen", o_cwen, 1);
    chk("t1_ctrl_wdata", o_cwd, exp_cw);
    chk("t1_ahb_wen", o_awen, 1);
    chk("t1_ahb_wdata", o_awd, 32'hA5A5_A5A5);
    repeat (2) cycle();
    // full flags gate eligibility
    ctrl_full = 1'b1;
    set_req(0, 1, 1, 32'h6000, 32'h6666);
    glog.delete();
    repeat (3) cycle();
    chk("t4_blocked", glog.size(), 0);
    ctrl_full = 1'b0;
    cycle();
    chk("t4_release", o_ready, 2'b01);
    cycle();
    ahb_data_full = 1'b1;
    set_req(0, 1, 1, 32'h6004, 32'h7777);
    set_req(1, 1, 0, 32'h7000, 0);
    cycle();
    chk("t4_read_only", o_ready, 2'b10);
    cycle();
    req_valid = '0;
    ahb_data_full = 1'b0;
    // read data lands in the same cycle a new read is recorded
    set_req(0, 1, 0, 32'h8000, 0);
    cycle();
    inject(32'hBEEF_0001);
    cycle();
    chk("t5_push", o_cwen, 1);
    chk("t5_pop", o_ren, 1);
    cycle();
    chk("t5_rsp_old", o_rsp, 2'b10);
    chk("t5_busy", o_busy, 1);
    inject(32'hBEEF_0002);
    repeat (2) cycle();
    chk("t5_rsp_new", o_rsp, 2'b01);
    cycle();
    chk("t5_idle", o_busy, 0);
    // asynchronous reset in the middle of a push
    set_req(1, 1, 0, 32'h9000, 0);
    repeat (2) cycle();
    set_req(0, 1, 0, 32'hA000, 0);
    cycle();
    resetn = 1'b0;
    #1;
    chk("t6_ctrl_wen", ctrl_wen, 0);
    chk("t6_busy", busy, 0);
    chk("t6_ready", req_ready, 0);
    model_reset();
    req_valid = '0;
    repeat (2) @(posedge pclk);
    #1;
    resetn = 1'b1;
    repeat (3) cycle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
